// File: rtl/pic_lay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_lay_pkg
// Purpose  : Shared Bayer site codes, position-FSM encoding and colour-bar table
// Revision : 1.0 - initial release
// ============================================================================
package pic_lay_pkg;

    localparam logic [1:0] SITE_R  = 2'b00;
    localparam logic [1:0] SITE_GR = 2'b01;
    localparam logic [1:0] SITE_GB = 2'b10;
    localparam logic [1:0] SITE_B  = 2'b11;

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } pos_state_t;

    // {R,G,B} per bar, index 0 (white) in the low slot, index 7 (black) on top
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
        if (idx > 4'd7)
            return 3'b000;
        return BAR_TABLE[idx[2:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : bayer_pos_counter
// Purpose  : Frame-sync FSM with X/Y raster counters and EOL/EOF/resync decode
// Revision : 1.0 - initial release
// ============================================================================
module bayer_pos_counter
    import pic_lay_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_dval,
    input  logic        i_sof,
    output logic        o_accept,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_sync_err
);

    localparam logic [15:0] c_X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] c_Y_LAST = 16'(V_ACTIVE - 1);

    pos_state_t  r_state, w_state_nxt;
    logic [15:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic        w_restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_SOF;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // A qualified SOF always places the pixel at (0,0), whatever the counters say
    always_comb begin
        w_restart   = i_dval & i_sof;
        o_accept    = i_dval & (w_restart | (r_state == ST_ACTIVE));
        o_x         = w_restart ? 16'd0 : r_x;
        o_y         = w_restart ? 16'd0 : r_y;
        o_eol       = o_accept & (o_x == c_X_LAST);
        o_eof       = o_eol & (o_y == c_Y_LAST);
        o_sync_err  = w_restart & (r_state == ST_ACTIVE) & ((r_x != 16'd0) | (r_y != 16'd0));
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (o_accept) begin
            w_state_nxt = ST_ACTIVE;
            if (o_eof) begin
                w_x_nxt     = 16'd0;
                w_y_nxt     = 16'd0;
                w_state_nxt = ST_WAIT_SOF;
            end else if (o_eol) begin
                w_x_nxt = 16'd0;
                w_y_nxt = o_y + 16'd1;
            end else begin
                w_x_nxt = o_x + 16'd1;
                w_y_nxt = o_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb2raw_mosaic.sv
`default_nettype none
// ============================================================================
// Module   : rgb2raw_mosaic
// Purpose  : RGB stream to Bayer RAW sample stream with X/Y counts, 1-cycle latency.
//            Optional colour-bar test pattern enabled by macro RGB2RAW_TESTPAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rgb2raw_mosaic
    import pic_lay_pkg::*;
#(
    parameter int         DATA_SIZE   = 8,
    parameter int         H_ACTIVE    = 1280,
    parameter int         V_ACTIVE    = 720,
    parameter logic [1:0] BAYER_PHASE = 2'b00
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [DATA_SIZE-1:0] iRed,
    input  logic [DATA_SIZE-1:0] iGreen,
    input  logic [DATA_SIZE-1:0] iBlue,
    input  logic                 iDVAL,
    input  logic                 iSOF,
`ifdef RGB2RAW_TESTPAT_EN
    input  logic                 iTP_EN,
`endif
    output logic [DATA_SIZE-1:0] oDATA,
    output logic                 oDVAL,
    output logic [15:0]          oX_Cont,
    output logic [15:0]          oY_Cont,
    output logic                 oEOL,
    output logic                 oEOF,
    output logic                 oSYNC_ERR
);

    logic                 w_accept, w_eol, w_eof, w_sync_err;
    logic [15:0]          w_x, w_y;
    logic [1:0]           w_site;
    logic [DATA_SIZE-1:0] w_red, w_green, w_blue, w_sample;

    bayer_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk        (iCLK),
        .rst        (iRST),
        .i_dval     (iDVAL),
        .i_sof      (iSOF),
        .o_accept   (w_accept),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_eol      (w_eol),
        .o_eof      (w_eof),
        .o_sync_err (w_sync_err)
    );

`ifdef RGB2RAW_TESTPAT_EN
    localparam int          c_BAR_W    = H_ACTIVE / 8;
    localparam logic [15:0] c_BAR_LAST = (c_BAR_W > 0) ? 16'(c_BAR_W - 1) : 16'd0;

    logic [15:0] r_bar_px, w_bar_px;
    logic [3:0]  r_bar_idx, w_bar_idx;
    logic [2:0]  w_bar;

    // Bar position restarts on every X=0 pixel; index saturates at 8 (black)
    always_comb begin
        w_bar_px  = (w_x == 16'd0) ? 16'd0 : r_bar_px;
        w_bar_idx = (w_x == 16'd0) ? 4'd0  : r_bar_idx;
        w_bar     = (c_BAR_W == 0) ? 3'b000 : bar_rgb(w_bar_idx);
        w_red     = iTP_EN ? {DATA_SIZE{w_bar[2]}} : iRed;
        w_green   = iTP_EN ? {DATA_SIZE{w_bar[1]}} : iGreen;
        w_blue    = iTP_EN ? {DATA_SIZE{w_bar[0]}} : iBlue;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (w_accept) begin
            if (w_bar_px == c_BAR_LAST) begin
                r_bar_px  <= '0;
                r_bar_idx <= (w_bar_idx == 4'd8) ? w_bar_idx : w_bar_idx + 4'd1;
            end else begin
                r_bar_px  <= w_bar_px + 16'd1;
                r_bar_idx <= w_bar_idx;
            end
        end
    end
`else
    assign w_red   = iRed;
    assign w_green = iGreen;
    assign w_blue  = iBlue;
`endif

    always_comb begin
        w_site = {w_y[0], w_x[0]} ^ BAYER_PHASE;
        case (w_site)
            SITE_R:  w_sample = w_red;
            SITE_B:  w_sample = w_blue;
            default: w_sample = w_green;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA     <= '0;
            oDVAL     <= 1'b0;
            oX_Cont   <= '0;
            oY_Cont   <= '0;
            oEOL      <= 1'b0;
            oEOF      <= 1'b0;
            oSYNC_ERR <= 1'b0;
        end else begin
            oDVAL     <= w_accept;
            oEOL      <= w_eol;
            oEOF      <= w_eof;
            oSYNC_ERR <= w_sync_err;
            if (w_accept) begin
                oDATA   <= w_sample;
                oX_Cont <= w_x;
                oY_Cont <= w_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb2raw_mosaic.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb2raw_mosaic
// Purpose  : Directed self-checking bench for rgb2raw_mosaic (4x2 frame)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb2raw_mosaic;

    logic       clk = 1'b0;
    logic       rst, dval, sof, tp_en;
    logic [7:0] r, g, b;
    int         cmp = 0;
    int         err = 0;

    logic [7:0]  d0, d3;
    logic        dv0, eol0, eof0, se0, dv3, eol3, eof3, se3;
    logic [15:0] x0, y0, x3, y3;

    always #5 clk = ~clk;

    rgb2raw_mosaic #(.DATA_SIZE(8), .H_ACTIVE(4), .V_ACTIVE(2), .BAYER_PHASE(2'b00)) u_dut (
        .iCLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval), .iSOF(sof),
`ifdef RGB2RAW_TESTPAT_EN
        .iTP_EN(1'b0),
`endif
        .oDATA(d0), .oDVAL(dv0), .oX_Cont(x0), .oY_Cont(y0),
        .oEOL(eol0), .oEOF(eof0), .oSYNC_ERR(se0));

    rgb2raw_mosaic #(.DATA_SIZE(8), .H_ACTIVE(4), .V_ACTIVE(2), .BAYER_PHASE(2'b11)) u_dut_p3 (
        .iCLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval), .iSOF(sof),
`ifdef RGB2RAW_TESTPAT_EN
        .iTP_EN(1'b0),
`endif
        .oDATA(d3), .oDVAL(dv3), .oX_Cont(x3), .oY_Cont(y3),
        .oEOL(eol3), .oEOF(eof3), .oSYNC_ERR(se3));

`ifdef RGB2RAW_TESTPAT_EN
    logic [7:0]  dt;
    logic        dvt, eolt, eoft, set;
    logic [15:0] xt, yt;

    rgb2raw_mosaic #(.DATA_SIZE(8), .H_ACTIVE(16), .V_ACTIVE(2), .BAYER_PHASE(2'b00)) u_dut_tp (
        .iCLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval), .iSOF(sof),
        .iTP_EN(tp_en),
        .oDATA(dt), .oDVAL(dvt), .oX_Cont(xt), .oY_Cont(yt),
        .oEOL(eolt), .oEOF(eoft), .oSYNC_ERR(set));
`endif

    // Drive one cycle of input at the falling edge, then settle just past the next rising edge
    task automatic px(input logic v, input logic s, input logic [7:0] rr, gg, bb);
        @(negedge clk);
        dval = v; sof = s; r = rr; g = gg; b = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dval = 1'b0; sof = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp++;
        if ({d0, dv0, x0, y0, eol0, eof0, se0} !== 43'd0) begin
            err++;
            $display("FAIL reset_outputs got %h required 0", {d0, dv0, x0, y0, eol0, eof0, se0});
        end
        cmp++;
        if ({d3, dv3} !== 9'd0) begin
            err++;
            $display("FAIL reset_outputs_p3 got %h required 0", {d3, dv3});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_sof();
        for (int n = 0; n < 3; n++) begin
            px(1'b1, 1'b0, 8'(1 + n), 8'(2 + n), 8'(3 + n));
            cmp++;
            if (dv0 !== 1'b0) begin
                err++;
                $display("FAIL no_sof_dval n=%0d got %b required 0", n, dv0);
            end
        end
    endtask

    task automatic test_frame();
        logic [7:0] e0 [8] = '{8'd10, 8'd21, 8'd12, 8'd23, 8'd24, 8'd35, 8'd26, 8'd37};
        logic [7:0] e3 [8] = '{8'd30, 8'd21, 8'd32, 8'd23, 8'd24, 8'd15, 8'd26, 8'd17};
        logic [35:0] exp_ctl;
        for (int n = 0; n < 8; n++) begin
            px(1'b1, n == 0, 8'(10 + n), 8'(20 + n), 8'(30 + n));
            exp_ctl = {1'b1, 16'(n % 4), 16'(n / 4), (n % 4) == 3, n == 7, 1'b0};
            cmp++;
            if (d0 !== e0[n]) begin
                err++;
                $display("FAIL frame_data n=%0d got %0d required %0d", n, d0, e0[n]);
            end
            cmp++;
            if ({dv0, x0, y0, eol0, eof0, se0} !== exp_ctl) begin
                err++;
                $display("FAIL frame_ctl n=%0d got %h required %h", n, {dv0, x0, y0, eol0, eof0, se0}, exp_ctl);
            end
            cmp++;
            if (d3 !== e3[n]) begin
                err++;
                $display("FAIL frame_phase3_data n=%0d got %0d required %0d", n, d3, e3[n]);
            end
        end
        px(1'b1, 1'b0, 8'd99, 8'd99, 8'd99);
        cmp++;
        if (dv0 !== 1'b0) begin
            err++;
            $display("FAIL after_eof_dval got %b required 0", dv0);
        end
    endtask

    task automatic test_gaps();
        logic       v [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       s [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] ed [7] = '{8'd40, 8'd40, 8'd52, 8'd52, 8'd44, 8'd44, 8'd56};
        logic [15:0] ex [7] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            px(v[n], s[n], 8'(40 + n), 8'(50 + n), 8'(60 + n));
            cmp++;
            if ({dv0, d0, x0, y0, eol0} !== {v[n], ed[n], ex[n], 16'd0, n == 6}) begin
                err++;
                $display("FAIL gaps n=%0d got %h required %h", n, {dv0, d0, x0, y0, eol0},
                         {v[n], ed[n], ex[n], 16'd0, n == 6});
            end
        end
    endtask

    task automatic test_resync();
        logic       s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] ed [4] = '{8'd60, 8'd71, 8'd62, 8'd73};
        logic [15:0] ex [4] = '{16'd0, 16'd1, 16'd0, 16'd1};
        logic       ese [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            px(1'b1, s[n], 8'(60 + n), 8'(70 + n), 8'(80 + n));
            cmp++;
            if ({dv0, d0, x0, y0, se0} !== {1'b1, ed[n], ex[n], 16'd0, ese[n]}) begin
                err++;
                $display("FAIL resync n=%0d got %h required %h", n, {dv0, d0, x0, y0, se0},
                         {1'b1, ed[n], ex[n], 16'd0, ese[n]});
            end
        end
    endtask

    // Continues from (2,0) left by test_resync
    task automatic test_reset_mid();
        for (int n = 0; n < 3; n++)
            px(1'b1, 1'b0, 8'd5, 8'd6, 8'd7);
        cmp++;
        if ({x0, y0} !== {16'd0, 16'd1}) begin
            err++;
            $display("FAIL pre_reset_pos got %h required %h", {x0, y0}, {16'd0, 16'd1});
        end
        @(negedge clk);
        dval = 1'b1; sof = 1'b0; r = 8'd77; g = 8'd78; b = 8'd79; rst = 1'b1;
        @(posedge clk);
        #1;
        cmp++;
        if ({d0, dv0, x0, y0, eol0, eof0, se0} !== 43'd0) begin
            err++;
            $display("FAIL mid_reset got %h required 0", {d0, dv0, x0, y0, eol0, eof0, se0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            px(1'b1, 1'b0, 8'd8, 8'd9, 8'd10);
            cmp++;
            if (dv0 !== 1'b0) begin
                err++;
                $display("FAIL post_reset_drop n=%0d got %b required 0", n, dv0);
            end
        end
        px(1'b1, 1'b1, 8'd90, 8'd91, 8'd92);
        cmp++;
        if ({dv0, d0, x0, y0} !== {1'b1, 8'd90, 16'd0, 16'd0}) begin
            err++;
            $display("FAIL post_reset_sof got %h required %h", {dv0, d0, x0, y0}, {1'b1, 8'd90, 32'd0});
        end
    endtask

`ifdef RGB2RAW_TESTPAT_EN
    task automatic test_testpat();
        logic [7:0] e;
        logic       chk;
        do_reset();
        tp_en = 1'b1;
        for (int n = 0; n < 32; n++) begin
            px(1'b1, n == 0, 8'd1, 8'd2, 8'd3);
            chk = 1'b1;
            case (n)
                0, 2, 3, 29: e = 8'd255;
                4, 14, 28:   e = 8'd0;
                default: begin e = 8'd0; chk = 1'b0; end
            endcase
            if (chk) begin
                cmp++;
                if ({dvt, dt} !== {1'b1, e}) begin
                    err++;
                    $display("FAIL testpat n=%0d got %h required %h", n, {dvt, dt}, {1'b1, e});
                end
            end
        end
        tp_en = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; dval = 1'b0; sof = 1'b0; tp_en = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        test_reset();
        test_no_sof();
        test_frame();
        test_gaps();
        test_resync();
        test_reset_mid();
`ifdef RGB2RAW_TESTPAT_EN
        test_testpat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
